// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four (a,b) combinations into a two-input all-gates unit and checks its seven outputs.
// Define GATE_SWEEP_STEP_EN to build the PAUSE state, which waits for a step pulse between combinations.
module gate_sweep_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    output logic       a,
    output logic       b,
    input  logic [6:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_vec,
    output logic [1:0] fail_idx,
    output logic       fail_valid,
    output logic [1:0] idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_PAUSE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [1:0] r_idx;
    logic [6:0] r_err;
    logic [1:0] r_fidx;
    logic       r_fval;
    logic       r_pass;
    logic       r_busy;
    logic       r_done;

    logic       w_a;
    logic       w_b;
    logic [6:0] w_mism;
    logic       w_settled;
    logic       w_accept;
    logic       w_check;
    logic       w_last;
    logic       w_cnt_run;

    // Truth table ordered {and, or, not a, nand, nor, xor, xnor}.
    function automatic logic [6:0] exp_vec(input logic ia, input logic ib);
        return {ia & ib, ia | ib, ~ia, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
    endfunction

    // Stimulus comes straight from idx, so a,b stay at 1,1 after a completed sweep.
    assign w_a       = r_idx[1];
    assign w_b       = r_idx[0];
    assign w_mism    = y ^ exp_vec(w_a, w_b);
    assign w_settled = (r_cnt == CNT_LAST);

`ifndef GATE_SWEEP_STEP_EN
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_APPLY;
            S_APPLY:  w_state_nxt = S_SETTLE;
            S_SETTLE: if (w_settled) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_DONE;
                end else begin
`ifdef GATE_SWEEP_STEP_EN
                    w_state_nxt = S_PAUSE;
`else
                    w_state_nxt = S_APPLY;
`endif
                end
            end
`ifdef GATE_SWEEP_STEP_EN
            S_PAUSE:  if (step) w_state_nxt = S_APPLY;
`endif
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = (r_state == S_IDLE) && start;
        w_check   = (r_state == S_CHECK);
        w_last    = (r_idx == 2'd3);
        w_cnt_run = (r_state == S_SETTLE) && !w_settled;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 2'd0;
            r_err   <= 7'd0;
            r_fidx  <= 2'd0;
            r_fval  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_cnt   <= w_cnt_run ? r_cnt + 8'd1 : 8'd0;
            if (w_accept) begin
                r_idx  <= 2'd0;
                r_err  <= 7'd0;
                r_fidx <= 2'd0;
                r_fval <= 1'b0;
                r_pass <= 1'b0;
            end
            if (w_check) begin
                r_err <= r_err | w_mism;
                if ((w_mism != 7'd0) && !r_fval) begin
                    r_fidx <= r_idx;
                    r_fval <= 1'b1;
                end
                // The last combination ends the sweep explicitly instead of letting idx wrap.
                if (w_last) r_pass <= ((r_err | w_mism) == 7'd0);
                else        r_idx  <= r_idx + 2'd1;
            end
        end
    end

    assign a          = w_a;
    assign b          = w_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_vec    = r_err;
    assign fail_idx   = r_fidx;
    assign fail_valid = r_fval;
    assign idx        = r_idx;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl (default build, SETTLE_CYC=2) with a faultable gate-unit model.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       step;
    logic       a, b;
    logic [6:0] y;
    logic       busy, done, pass, fail_valid;
    logic [6:0] err_vec;
    logic [1:0] fail_idx, idx;

    int total = 0;
    int bad   = 0;
    int fmode = 0;

    always #5 clk = ~clk;

    gate_sweep_ctrl #(.SETTLE_CYC(2)) dut (
        .CLOCK_50(clk), .rst(rst), .start(start), .step(step),
        .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_vec(err_vec),
        .fail_idx(fail_idx), .fail_valid(fail_valid), .idx(idx)
    );

    // Gate unit as a truth-table lookup, {and,or,nota,nand,nor,xor,xnor}, plus injectable faults.
    logic [6:0] y_good;
    always_comb begin
        case ({a, b})
            2'b00:   y_good = 7'b0011101;
            2'b01:   y_good = 7'b0111010;
            2'b10:   y_good = 7'b0101010;
            default: y_good = 7'b1100001;
        endcase
        y = y_good;
        case (fmode)
            1: if ({a, b} == 2'b10) y = y_good ^ 7'b0000010;
            2: y = y_good & 7'b0111111;
            3: y = y_good | 7'b0000001;
            4: y = y_good ^ 7'b0010000;
            5: y = 7'b0000000;
            default: y = y_good;
        endcase
    end

    typedef struct {
        int         fm;
        int         restart_at;
        logic       exp_pass;
        logic [6:0] exp_err;
        logic [1:0] exp_fidx;
        logic       exp_fval;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {18'd0, a, b, busy, done, pass, err_vec, fail_idx, fail_valid, idx}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 1'b1, 7'b0000000, 2'd0, 1'b0};
        vecs[1] = '{1, 6, 1'b0, 7'b0000010, 2'd2, 1'b1};
        vecs[2] = '{2, 0, 1'b0, 7'b1000000, 2'd3, 1'b1};
        vecs[3] = '{3, 11, 1'b0, 7'b0000001, 2'd1, 1'b1};
        vecs[4] = '{4, 0, 1'b0, 7'b0010000, 2'd0, 1'b1};
        vecs[5] = '{5, 0, 1'b0, 7'b1111111, 2'd0, 1'b1};

        rst = 1'b1; start = 1'b0; step = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_all_zero("idle_after_reset");
        end

        for (int i = 0; i < 6; i++) begin
            fmode = vecs[i].fm;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                chk("sweep_ab", {30'd0, a, b}, 32'((c - 1) / 4));
                chk("sweep_idx", {30'd0, idx}, 32'((c - 1) / 4));
                chk("sweep_busy_done", {30'd0, busy, done}, 32'b10);
                if (c == 1) chk("start_clears", {24'd0, pass, err_vec}, 32'd0);
                start = (c == vecs[i].restart_at);
                tick();
            end
            start = 1'b0;
            chk("done_cycle", {30'd0, busy, done}, 32'b11);
            chk("pass", {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            chk("err_vec", {25'd0, err_vec}, {25'd0, vecs[i].exp_err});
            chk("fail_idx", {30'd0, fail_idx}, {30'd0, vecs[i].exp_fidx});
            chk("fail_valid", {31'd0, fail_valid}, {31'd0, vecs[i].exp_fval});
            tick();
            chk("after_done", {30'd0, busy, done}, 32'b00);
            chk("ab_hold_11", {30'd0, a, b}, 32'b11);
            tick();
            tick();
            chk("result_held", {24'd0, pass, err_vec}, {24'd0, vecs[i].exp_pass, vecs[i].exp_err});
        end

        // Reset while in SETTLE of combination 1, right after a sweep that left every error bit set.
        fmode = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_reset_ab", {30'd0, a, b}, 32'b01);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("reset_mid_sweep");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all_zero("idle_after_mid_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
